// File: rtl/flex_counter_pkg.sv
// Shared widths and configuration encodings for the flex step counter.
package flex_counter_pkg;

    localparam int DEFAULT_NUM_BITS  = 7;
    localparam int DEFAULT_INCR_BITS = 3;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    typedef enum logic {
        MODE_WRAP    = 1'b0,
        MODE_ONESHOT = 1'b1
    } mode_e;

endpackage

// File: rtl/flex_counter_status.sv
// Combinational status decode: terminal flag, square wave, one-shot done and
// configuration error, all derived from the registered count and live inputs.
module flex_counter_status
    import flex_counter_pkg::*;
#(
    parameter int NUM_BITS  = DEFAULT_NUM_BITS,
    parameter int INCR_BITS = DEFAULT_INCR_BITS
) (
    input  logic [NUM_BITS-1:0]  count_i,
    input  logic [NUM_BITS-1:0]  rollover_val_i,
    input  logic [INCR_BITS-1:0] incr_val_i,
    input  dir_e                 dir_i,
    input  mode_e                mode_i,
    output logic                 rollover_flag_o,
    output logic                 sqwave_o,
    output logic                 done_o,
    output logic                 err_o
);

    localparam int W = NUM_BITS + 1;

    logic [NUM_BITS-1:0] terminal;
    logic                at_terminal;
    logic [W-1:0]        incr_ext;
    logic [W-1:0]        roll_ext;

    always_comb begin
        terminal    = (dir_i == DIR_DOWN) ? '0 : rollover_val_i;
        at_terminal = (count_i == terminal);
        incr_ext    = W'(incr_val_i);
        roll_ext    = {1'b0, rollover_val_i};

        rollover_flag_o = at_terminal;
        done_o          = (mode_i == MODE_ONESHOT) && at_terminal;
        // High for the upper half of the range, same threshold in either direction.
        sqwave_o        = !(count_i < (rollover_val_i >> 1));
        err_o           = (rollover_val_i[NUM_BITS-1:1] == '0)
                        || (incr_val_i == '0)
                        || (incr_ext > roll_ext);
    end

endmodule

// File: rtl/flex_step_counter.sv
// Rollover counter with programmable step, direction and wrap/one-shot mode.
// The count register is the only state; status outputs are decoded from it.
module flex_step_counter
    import flex_counter_pkg::*;
#(
    parameter int NUM_BITS  = DEFAULT_NUM_BITS,
    parameter int INCR_BITS = DEFAULT_INCR_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 count_enable,
    input  logic                 count_down,
    input  logic                 one_shot,
    input  logic [NUM_BITS-1:0]  rollover_val,
    input  logic [INCR_BITS-1:0] incr_val,
    output logic [NUM_BITS-1:0]  count_out,
    output logic                 rollover_flag,
    output logic                 sqwave,
    output logic                 done,
    output logic                 err
);

    localparam int W = NUM_BITS + 1;

    logic [NUM_BITS-1:0] count_q;
    logic [NUM_BITS-1:0] count_d;
    logic [W-1:0]        incr_ext;
    logic [W-1:0]        sum;
    logic [NUM_BITS-1:0] incr_n;
    dir_e                dir;
    mode_e               mode;

    assign dir  = dir_e'(count_down);
    assign mode = mode_e'(one_shot);

    // NOTE: every variable gets a default before any branch so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        count_d  = count_q;
        incr_ext = W'(incr_val);
        incr_n   = NUM_BITS'(incr_val);
        sum      = {1'b0, count_q} + incr_ext;

        if (clear) begin
            count_d = '0;
        end else if (count_enable) begin
            if (dir == DIR_UP) begin
                if (count_q >= rollover_val) begin
                    count_d = (mode == MODE_WRAP) ? '0 : count_q;
                end else if (sum > {1'b0, rollover_val}) begin
                    count_d = rollover_val;
                end else begin
                    count_d = sum[NUM_BITS-1:0];
                end
            end else begin
                if (count_q == '0) begin
                    count_d = (mode == MODE_WRAP) ? rollover_val : count_q;
                end else if (incr_ext >= {1'b0, count_q}) begin
                    count_d = '0;
                end else begin
                    count_d = count_q - incr_n;
                end
            end
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_out = count_q;

    flex_counter_status #(
        .NUM_BITS (NUM_BITS),
        .INCR_BITS(INCR_BITS)
    ) u_status (
        .count_i        (count_q),
        .rollover_val_i (rollover_val),
        .incr_val_i     (incr_val),
        .dir_i          (dir),
        .mode_i         (mode),
        .rollover_flag_o(rollover_flag),
        .sqwave_o       (sqwave),
        .done_o         (done),
        .err_o          (err)
    );

endmodule

// File: tb/tb_flex_step_counter.sv
// Self-checking bench: directed scenarios plus randomized traffic, compared
// each cycle against an integer reference model of the counting rules.
module tb_flex_step_counter;

    logic       clk = 1'b0;
    logic       rst;
    logic       clear;
    logic       count_enable;
    logic       count_down;
    logic       one_shot;
    logic [6:0] rollover_val;
    logic [2:0] incr_val;
    logic [6:0] count_out;
    logic       rollover_flag;
    logic       sqwave;
    logic       done;
    logic       err;

    int n_checks = 0;
    int n_errors = 0;
    int m_count  = 0;

    int step_seq[6] = '{3, 6, 9, 10, 0, 3};
    int down_seq[5] = '{10, 6, 2, 0, 10};
    int os_seq[5]   = '{2, 4, 5, 5, 5};

    always #5 clk = ~clk;

    flex_step_counter dut (
        .clk          (clk),
        .rst          (rst),
        .clear        (clear),
        .count_enable (count_enable),
        .count_down   (count_down),
        .one_shot     (one_shot),
        .rollover_val (rollover_val),
        .incr_val     (incr_val),
        .count_out    (count_out),
        .rollover_flag(rollover_flag),
        .sqwave       (sqwave),
        .done         (done),
        .err          (err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int model_next(input int c);
        int r;
        int inc;
        r   = int'(rollover_val);
        inc = int'(incr_val);
        if (rst || clear) return 0;
        if (!count_enable) return c;
        if (!count_down) begin
            if (c >= r) return one_shot ? c : 0;
            return (c + inc > r) ? r : c + inc;
        end
        if (c == 0) return one_shot ? 0 : r;
        return (c - inc < 0) ? 0 : c - inc;
    endfunction

    task automatic check_outputs();
        int r;
        int inc;
        int t;
        r   = int'(rollover_val);
        inc = int'(incr_val);
        t   = count_down ? 0 : r;
        check("no_x", 32'($isunknown({count_out, rollover_flag, sqwave, done, err})), 0);
        check("count", count_out, m_count);
        check("rollover_flag", rollover_flag, (m_count == t) ? 1 : 0);
        check("done", done, (one_shot && m_count == t) ? 1 : 0);
        check("sqwave", sqwave, (m_count < r / 2) ? 0 : 1);
        check("err", err, (r < 2 || inc == 0 || inc > r) ? 1 : 0);
    endtask

    // Advance one edge: the model sees the same pre-edge inputs as the DUT.
    task automatic cycle();
        @(posedge clk);
        m_count = model_next(m_count);
        #1;
        check_outputs();
    endtask

    task automatic do_clear();
        clear = 1'b1;
        cycle();
        clear = 1'b0;
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0; count_enable = 1'b0; count_down = 1'b0;
        one_shot = 1'b0; rollover_val = 7'd72; incr_val = 3'd1;
        cycle();
        cycle();
        check("reset_count", count_out, 0);
        rst = 1'b0;

        // Reset mid-run: count holds until the edge, then zero while held.
        count_enable = 1'b1;
        repeat (20) cycle();
        check("pre_rst_count", count_out, 20);
        rst = 1'b1;
        #1;
        check("rst_before_edge", count_out, 20);
        cycle();
        check("rst_edge1", count_out, 0);
        cycle();
        check("rst_edge2", count_out, 0);
        rst = 1'b0;

        // Up wrap across the full 0..72 range.
        for (int i = 0; i < 74; i++) begin
            cycle();
            if (i == 34) check("up_sq_low", sqwave, 0);
            if (i == 35) check("up_sq_high", sqwave, 1);
            if (i == 71) check("up_at_72", count_out, 72);
            if (i == 72) check("up_wrap0", count_out, 0);
        end

        // Step with clamp onto the terminal.
        rollover_val = 7'd10; incr_val = 3'd3;
        do_clear();
        for (int i = 0; i < 6; i++) begin
            cycle();
            check("step_seq", count_out, step_seq[i]);
        end
        rollover_val = 7'd127; incr_val = 3'd7;
        do_clear();
        repeat (18) cycle();
        check("at_126", count_out, 126);
        cycle();
        check("clamp_127", count_out, 127);
        check("flag_127", rollover_flag, 1);
        cycle();
        check("wrap_from_127", count_out, 0);

        // Down wrap reloading from rollover_val.
        rollover_val = 7'd10; incr_val = 3'd4; count_down = 1'b1;
        do_clear();
        check("down_flag_at0", rollover_flag, 1);
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("down_seq", count_out, down_seq[i]);
        end

        // One-shot hold and clear priority over enable.
        count_down = 1'b0; one_shot = 1'b1; rollover_val = 7'd5; incr_val = 3'd2;
        do_clear();
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("os_seq", count_out, os_seq[i]);
            if (i >= 2) check("os_done", done, 1);
        end
        do_clear();
        check("clear_over_en", count_out, 0);
        check("clear_done", done, 0);
        one_shot = 1'b0;

        // Configuration errors.
        rollover_val = 7'd0; incr_val = 3'd1;
        repeat (3) cycle();
        check("r0_count", count_out, 0);
        check("r0_err", err, 1);
        rollover_val = 7'd1;
        #1;
        check("r1_err", err, 1);
        rollover_val = 7'd10; incr_val = 3'd3;
        do_clear();
        repeat (2) cycle();
        incr_val = 3'd0;
        repeat (3) cycle();
        check("inc0_hold", count_out, 6);
        check("inc0_err", err, 1);
        rollover_val = 7'd5; incr_val = 3'd6;
        #1;
        check("inc_gt_r_err", err, 1);
        rollover_val = 7'd72; incr_val = 3'd7;
        #1;
        check("ok_err", err, 0);

        // Randomized traffic with mid-run configuration changes.
        for (int i = 0; i < 3000; i++) begin
            rst          = ($urandom_range(99) < 2);
            clear        = ($urandom_range(99) < 4);
            count_enable = ($urandom_range(99) < 80);
            if ($urandom_range(99) < 5) count_down = $urandom_range(1);
            if ($urandom_range(99) < 5) one_shot = $urandom_range(1);
            if ($urandom_range(99) < 3) rollover_val = 7'($urandom_range(127));
            if ($urandom_range(99) < 5) incr_val = 3'($urandom_range(7));
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
